// File: rtl/branch_resolve_pipe_pkg.sv
// Shared types for the buffered branch resolver: condition encodings and
// default-width entry/result records.
package branch_resolve_pipe_pkg;

  typedef enum logic [2:0] {
    F_BEQ  = 3'd0,
    F_BNE  = 3'd1,
    F_BLT  = 3'd2,
    F_BLE  = 3'd3,
    F_FBLT = 3'd4,
    F_FBLE = 3'd5,
    F_FBPL = 3'd6,
    F_FBNG = 3'd7
  } funct_e;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_ID_W = 6;

  // Default-width layouts; the top re-declares them at its own XLEN/ID_W
  // and hands the entry type to the condition evaluator.
  typedef struct packed {
    logic [DEF_ID_W-1:0] commit_id;
    funct_e              funct;
    logic                jr;
    logic                approx;
    logic [DEF_XLEN-1:0] src1;
    logic [DEF_XLEN-1:0] src2;
    logic [DEF_XLEN-1:0] target;
  } br_entry_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0] commit_id;
    logic                taken;
    logic                miss;
    logic [DEF_XLEN-1:0] new_pc;
  } br_result_t;

endpackage

// File: rtl/branch_resolve_pipe_cond.sv
// Combinational branch condition for one queued entry, including the
// sign-magnitude float less-than.
module branch_cond_eval
  import branch_resolve_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          SIGNED_CMP = 1'b0,
  parameter bit          FLOAT_EN   = 1'b1,
  parameter type         entry_t    = br_entry_t
) (
  input  entry_t entry,
  output logic   cond
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic eq;
  logic lt;
  logic flt;
  logic fle;
  logic fpos;
  logic fneg;

  assign a  = entry.src1;
  assign b  = entry.src2;
  assign eq = (a == b);

  if (SIGNED_CMP) begin : g_signed
    assign lt = ($signed(a) < $signed(b));
  end else begin : g_unsigned
    assign lt = (a < b);
  end

  if (FLOAT_EN) begin : g_float
    always_comb begin
      flt = 1'b0;
      case ({a[31], b[31]})
        2'b00:   flt = (a[30:0] < b[30:0]);
        2'b11:   flt = (a[30:0] > b[30:0]);
        2'b10:   flt = 1'b1;
        default: flt = 1'b0;
      endcase
    end
    assign fle  = flt | eq;
    assign fpos = ~b[31];
    assign fneg = b[31];
  end else begin : g_no_float
    assign flt  = 1'b0;
    assign fle  = 1'b0;
    assign fpos = 1'b0;
    assign fneg = 1'b0;
  end

  always_comb begin
    cond = 1'b0;
    case (entry.funct)
      F_BEQ:  cond = eq;
      F_BNE:  cond = ~eq;
      F_BLT:  cond = lt;
      F_BLE:  cond = lt | eq;
      F_FBLT: cond = flt;
      F_FBLE: cond = fle;
      F_FBPL: cond = fpos;
      F_FBNG: cond = fneg;
    endcase
  end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Buffered branch resolver: DEPTH-entry input FIFO, one resolve per cycle
// into a registered commit-bus stage, with saturating statistics.
module branch_resolve_pipe
  import branch_resolve_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ID_W       = 6,
  parameter int unsigned DEPTH      = 4,
  parameter bit          SIGNED_CMP = 1'b0,
  parameter bit          FLOAT_EN   = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_commit_id,
  input  logic [2:0]       in_funct,
  input  logic             in_jr,
  input  logic             in_approx,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [XLEN-1:0]  in_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_commit_id,
  output logic             out_taken,
  output logic             out_miss,
  output logic [XLEN-1:0]  out_new_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_misses
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (FLOAT_EN && XLEN != 32) begin : g_bad_float
    $error("branch_resolve_pipe: FLOAT_EN requires XLEN == 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_resolve_pipe: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [ID_W-1:0] commit_id;
    funct_e          funct;
    logic            jr;
    logic            approx;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] target;
  } pipe_entry_t;

  typedef struct packed {
    logic [ID_W-1:0] commit_id;
    logic            taken;
    logic            miss;
    logic [XLEN-1:0] new_pc;
  } pipe_result_t;

  pipe_entry_t  mem [DEPTH];
  pipe_entry_t  in_entry;
  pipe_entry_t  head;
  pipe_result_t res;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic handshake;
  logic cond;

  always_comb begin
    in_entry.commit_id = in_commit_id;
    in_entry.funct     = funct_e'(in_funct);
    in_entry.jr        = in_jr;
    in_entry.approx    = in_approx;
    in_entry.src1      = in_src1;
    in_entry.src2      = in_src2;
    in_entry.target    = in_target;
  end

  // Ready comes only from the registered count, so a full FIFO stays
  // not-ready even in a cycle where the head is being popped.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign pop       = ~empty & (~out_valid | out_ready);
  assign handshake = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  branch_cond_eval #(
    .XLEN       (XLEN),
    .SIGNED_CMP (SIGNED_CMP),
    .FLOAT_EN   (FLOAT_EN),
    .entry_t    (pipe_entry_t)
  ) u_cond (
    .entry (head),
    .cond  (cond)
  );

  always_comb begin
    res.commit_id = head.commit_id;
    res.taken     = cond | head.jr;
    res.miss      = (cond ^ head.approx) | head.jr;
    res.new_pc    = head.jr ? head.src2 : head.target;
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_valid     <= 1'b0;
      out_commit_id <= '0;
      out_taken     <= 1'b0;
      out_miss      <= 1'b0;
      out_new_pc    <= '0;
      stat_branches <= '0;
      stat_misses   <= '0;
    end else begin
      // A handshake coinciding with flush still retires its result.
      if (handshake && stat_branches != '1) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (handshake && out_miss && stat_misses != '1) begin
        stat_misses <= stat_misses + CNT_W'(1);
      end

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr        <= rd_ptr + AW'(1);
          out_valid     <= 1'b1;
          out_commit_id <= res.commit_id;
          out_taken     <= res.taken;
          out_miss      <= res.miss;
          out_new_pc    <= res.new_pc;
        end else if (handshake) begin
          out_valid <= 1'b0;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Bench for branch_resolve_pipe: an unsigned/32-bit-counter instance and a
// signed/4-bit-counter instance share one stimulus stream.
module tb_branch_resolve_pipe;
  import branch_resolve_pipe_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ID_W  = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NVEC  = 14;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [ID_W-1:0] in_commit_id;
  logic [2:0] in_funct;
  logic in_jr;
  logic in_approx;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_target;
  logic flush;
  logic out_ready;

  logic in_ready_a, out_valid_a, out_taken_a, out_miss_a;
  logic [ID_W-1:0] out_commit_id_a;
  logic [XLEN-1:0] out_new_pc_a;
  logic [31:0] stat_br_a, stat_mis_a;

  logic in_ready_b, out_valid_b, out_taken_b, out_miss_b;
  logic [ID_W-1:0] out_commit_id_b;
  logic [XLEN-1:0] out_new_pc_b;
  logic [3:0] stat_br_b, stat_mis_b;

  always #5 clk = ~clk;

  branch_resolve_pipe #(
    .XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH),
    .SIGNED_CMP(1'b0), .FLOAT_EN(1'b1), .CNT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_commit_id(in_commit_id), .in_funct(in_funct), .in_jr(in_jr),
    .in_approx(in_approx), .in_src1(in_src1), .in_src2(in_src2),
    .in_target(in_target), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_commit_id(out_commit_id_a),
    .out_taken(out_taken_a), .out_miss(out_miss_a), .out_new_pc(out_new_pc_a),
    .stat_branches(stat_br_a), .stat_misses(stat_mis_a)
  );

  branch_resolve_pipe #(
    .XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH),
    .SIGNED_CMP(1'b1), .FLOAT_EN(1'b1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_commit_id(in_commit_id), .in_funct(in_funct), .in_jr(in_jr),
    .in_approx(in_approx), .in_src1(in_src1), .in_src2(in_src2),
    .in_target(in_target), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_commit_id(out_commit_id_b),
    .out_taken(out_taken_b), .out_miss(out_miss_b), .out_new_pc(out_new_pc_b),
    .stat_branches(stat_br_b), .stat_misses(stat_mis_b)
  );

  // tu/mu: expected taken/miss with unsigned compare; ts/ms: signed compare.
  typedef struct {
    logic [2:0]  funct;
    logic        jr;
    logic        approx;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] target;
    logic        tu, mu, ts, ms;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            tu, mu, ts, ms;
    logic [31:0]     pc;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sbq [$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cur_idx = 0;
  logic [31:0] exp_br_a, exp_mis_a;
  logic [3:0]  exp_br_b, exp_mis_b;
  logic [31:0] base_br, base_mis, hold_pc;
  logic [ID_W-1:0] hold_id;
  logic hold_t, hold_m;

  function automatic vec_t mk(input logic [2:0] f, input logic jr, input logic ap,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] tg, input logic tu, input logic mu,
                              input logic ts, input logic ms, input logic [31:0] pc);
    vec_t v;
    v.funct = f; v.jr = jr; v.approx = ap; v.src1 = s1; v.src2 = s2; v.target = tg;
    v.tu = tu; v.mu = mu; v.ts = ts; v.ms = ms; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [ID_W-1:0] id);
    cur_idx      = idx;
    in_commit_id = id;
    in_funct     = vecs[idx].funct;
    in_jr        = vecs[idx].jr;
    in_approx    = vecs[idx].approx;
    in_src1      = vecs[idx].src1;
    in_src2      = vecs[idx].src2;
    in_target    = vecs[idx].target;
    in_valid     = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: got no in_ready expected in_ready within 60 cycles");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    check("drain_complete", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each output handshake, push on each accepted enqueue.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      exp_br_a = '0; exp_mis_a = '0; exp_br_b = '0; exp_mis_b = '0;
    end else begin
      check("stat_branches_a", stat_br_a, exp_br_a);
      check("stat_misses_a", stat_mis_a, exp_mis_a);
      check("stat_branches_b", 32'(stat_br_b), 32'(exp_br_b));
      check("stat_misses_b", 32'(stat_mis_b), 32'(exp_mis_b));
      check("no_overflow_a", 32'(dut_a.count <= DEPTH), 32'd1);
      check("no_overflow_b", 32'(dut_b.count <= DEPTH), 32'd1);
      if (out_valid_a && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got id 0x%0h expected no output", out_commit_id_a);
        end else begin
          mon_e = sbq.pop_front();
          check("out_commit_id_a", 32'(out_commit_id_a), 32'(mon_e.id));
          check("out_taken_a", 32'(out_taken_a), 32'(mon_e.tu));
          check("out_miss_a", 32'(out_miss_a), 32'(mon_e.mu));
          check("out_new_pc_a", out_new_pc_a, mon_e.pc);
          check("out_valid_b", 32'(out_valid_b), 32'd1);
          check("out_commit_id_b", 32'(out_commit_id_b), 32'(mon_e.id));
          check("out_taken_b", 32'(out_taken_b), 32'(mon_e.ts));
          check("out_miss_b", 32'(out_miss_b), 32'(mon_e.ms));
          check("out_new_pc_b", out_new_pc_b, mon_e.pc);
          exp_br_a++;
          if (mon_e.mu) exp_mis_a++;
          if (exp_br_b != 4'hF) exp_br_b++;
          if (mon_e.ms && exp_mis_b != 4'hF) exp_mis_b++;
        end
      end
      if (flush) begin
        sbq.delete();
      end else if (in_valid && in_ready_a) begin
        mon_e.id = in_commit_id;
        mon_e.tu = vecs[cur_idx].tu;
        mon_e.mu = vecs[cur_idx].mu;
        mon_e.ts = vecs[cur_idx].ts;
        mon_e.ms = vecs[cur_idx].ms;
        mon_e.pc = vecs[cur_idx].pc;
        sbq.push_back(mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(3'd2, 0, 0, 32'd5,         32'd7,         32'h100, 1, 1, 1, 1, 32'h100);
    vecs[1]  = mk(3'd2, 0, 0, 32'hFFFFFFFF,  32'd1,         32'h200, 0, 0, 1, 1, 32'h200);
    vecs[2]  = mk(3'd4, 0, 1, 32'h80000000,  32'h00000000,  32'h300, 1, 0, 1, 0, 32'h300);
    vecs[3]  = mk(3'd5, 0, 0, 32'h3F800000,  32'h3F800000,  32'h400, 1, 1, 1, 1, 32'h400);
    vecs[4]  = mk(3'd4, 0, 1, 32'hC0000000,  32'hBF800000,  32'h500, 1, 0, 1, 0, 32'h500);
    vecs[5]  = mk(3'd0, 1, 1, 32'd1,         32'h2000,      32'h600, 1, 1, 1, 1, 32'h2000);
    vecs[6]  = mk(3'd0, 0, 1, 32'h1234,      32'h1234,      32'h700, 1, 0, 1, 0, 32'h700);
    vecs[7]  = mk(3'd1, 0, 1, 32'd3,         32'd3,         32'h800, 0, 1, 0, 1, 32'h800);
    vecs[8]  = mk(3'd3, 0, 0, 32'd7,         32'd7,         32'h900, 1, 1, 1, 1, 32'h900);
    vecs[9]  = mk(3'd3, 0, 1, 32'd1,         32'hFFFFFFFE,  32'hA00, 1, 0, 0, 1, 32'hA00);
    vecs[10] = mk(3'd6, 0, 0, 32'd0,         32'h7FFFFFFF,  32'hB00, 1, 1, 1, 1, 32'hB00);
    vecs[11] = mk(3'd7, 0, 0, 32'd0,         32'h7FFFFFFF,  32'hC00, 0, 0, 0, 0, 32'hC00);
    vecs[12] = mk(3'd4, 0, 0, 32'h00000000,  32'h80000000,  32'hD00, 0, 0, 0, 0, 32'hD00);
    vecs[13] = mk(3'd4, 0, 0, 32'h3F800000,  32'h40000000,  32'hE00, 1, 1, 1, 1, 32'hE00);

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_commit_id = '0; in_funct = '0; in_jr = 1'b0; in_approx = 1'b0;
    in_src1 = '0; in_src2 = '0; in_target = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 32'(out_valid_a), 32'd0);
    check("reset_out_commit_id", 32'(out_commit_id_a), 32'd0);
    check("reset_out_taken", 32'(out_taken_a), 32'd0);
    check("reset_out_miss", 32'(out_miss_a), 32'd0);
    check("reset_out_new_pc", out_new_pc_a, 32'd0);
    check("reset_in_ready_a", 32'(in_ready_a), 32'd1);
    check("reset_in_ready_b", 32'(in_ready_b), 32'd1);
    @(posedge clk);
    #1;

    // Minimum latency: accepted at edge t, visible after edge t+1.
    drive(0, 6'd1);
    @(negedge clk);
    check("latency_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_after_t", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    check("latency_after_t1", 32'(out_valid_a), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(i, 6'(i + 2));
      wait_accept();
    end
    drain();

    // Backpressure: DEPTH in the FIFO plus one held in the output register.
    out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      drive(i, 6'(20 + i));
      wait_accept();
    end
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready_a), 32'd0);
    check("bp_head_id", 32'(out_commit_id_a), 32'd20);
    hold_id = out_commit_id_a; hold_t = out_taken_a; hold_m = out_miss_a; hold_pc = out_new_pc_a;
    repeat (3) @(negedge clk);
    check("bp_hold_id", 32'(out_commit_id_a), 32'(hold_id));
    check("bp_hold_taken", 32'(out_taken_a), 32'(hold_t));
    check("bp_hold_miss", 32'(out_miss_a), 32'(hold_m));
    check("bp_hold_pc", out_new_pc_a, hold_pc);
    check("bp_hold_valid", 32'(out_valid_a), 32'd1);
    @(posedge clk);
    #1;
    base_br = stat_br_a;
    out_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      @(negedge clk);
      if (i == 0) check("full_dequeue_in_ready", 32'(in_ready_a), 32'd0);
      check("bp_no_gap", 32'(out_valid_a), 32'd1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_stat_delta", stat_br_a - base_br, 32'(DEPTH + 1));
    check("bp_drained", 32'(out_valid_a), 32'd0);
    @(posedge clk);
    #1;

    // Flush with three entries queued, one in the output register, and an
    // enqueue offered on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6 + i, 6'(30 + i));
      wait_accept();
    end
    base_br = stat_br_a;
    base_mis = stat_mis_a;
    drive(10, 6'd40);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready_a), 32'd1);
    check("flush_pre_valid", 32'(out_valid_a), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid_a), 32'd0);
    check("flush_fifo_empty", 32'(dut_a.count), 32'd0);
    check("flush_in_ready_after", 32'(in_ready_a), 32'd1);
    check("flush_branches_kept", stat_br_a, base_br);
    check("flush_misses_kept", stat_mis_a, base_mis);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush_no_ghost", 32'(out_valid_a), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset in the middle of traffic discards everything.
    out_ready = 1'b0;
    drive(0, 6'd50);
    wait_accept();
    drive(1, 6'd51);
    wait_accept();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid_a), 32'd0);
    check("midreset_fifo_empty", 32'(dut_a.count), 32'd0);
    check("midreset_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Saturation of the 4-bit counters after 16 mispredicts.
    for (int i = 0; i < 16; i++) begin
      drive(0, 6'(i));
      wait_accept();
    end
    drain();
    @(negedge clk);
    check("sat_misses_b", 32'(stat_mis_b), 32'd15);
    check("sat_branches_b", 32'(stat_br_b), 32'd15);
    check("unsat_misses_a", stat_mis_a, 32'd16);
    check("unsat_branches_a", stat_br_a, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
